// File: rtl/sa_cache_4way.sv
// 4-way set-associative write-back, write-allocate data cache (256 sets x 16 words).
// Hits finish in one cycle; misses stream out a dirty victim, refill word by word, then replay.
module sa_cache_4way (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] i_tag,
  input  logic [7:0]  i_index,
  input  logic [5:0]  i_offset,
  input  logic [31:0] dataW,
  input  logic        memRW,
  input  logic [31:0] i_memory_line,
  input  logic        i_memory_response,
  output logic [31:0] o_data,
  output logic [31:0] line_data,
  output logic        cache_miss,
  output logic [31:0] o_evict_data,
  output logic [31:0] o_evict_addr,
  output logic        o_evict
);

  typedef enum logic [1:0] {S_IDLE, S_EVICT, S_REFILL} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  vic_q, vic_d;
  logic [7:0]  idx_q, idx_d;
  logic [17:0] rtag_q, rtag_d;
  logic [31:0] data_q, data_d;
  logic [31:0] line_q, line_d;
  logic [31:0] ev_data_q, ev_data_d;
  logic [31:0] ev_addr_q, ev_addr_d;
  logic        miss_q, miss_d;
  logic        ev_q, ev_d;

  logic [3:0]  valid_q [256];
  logic [3:0]  dirty_q [256];
  logic [1:0]  age_q   [256][4];
  logic [17:0] tag_mem [4][256];
  logic [31:0] data_mem [16384];

  logic [3:0]  word;
  logic        unused_offset;
  assign word          = i_offset[5:2];
  assign unused_offset = &{1'b0, i_offset[1:0]};

  logic        hit;
  logic [1:0]  hit_way;
  logic [1:0]  vic_sel;
  logic        vic_found;
  logic        lru_upd, st_wr, miss_start, fill_done, mem_we;
  logic [13:0] mem_waddr;
  logic [31:0] mem_wdat;

  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int w = 0; w < 4; w++) begin
      if (valid_q[i_index][w] && tag_mem[w][i_index] == i_tag) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise the way whose age is 3.
  always_comb begin
    vic_sel   = 2'd0;
    vic_found = 1'b0;
    for (int w = 3; w >= 0; w--) begin
      if (!valid_q[i_index][w]) begin
        vic_sel   = 2'(w);
        vic_found = 1'b1;
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < 4; w++) begin
        if (age_q[i_index][w] == 2'd3) vic_sel = 2'(w);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vic_d      = vic_q;
    idx_d      = idx_q;
    rtag_d     = rtag_q;
    data_d     = data_q;
    line_d     = line_q;
    miss_d     = miss_q;
    ev_d       = 1'b0;
    ev_data_d  = ev_data_q;
    ev_addr_d  = ev_addr_q;
    lru_upd    = 1'b0;
    st_wr      = 1'b0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = {hit_way, i_index, word};
    mem_wdat   = dataW;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          lru_upd = 1'b1;
          if (memRW) begin
            st_wr  = 1'b1;
            mem_we = 1'b1;
          end else begin
            data_d = data_mem[{hit_way, i_index, word}];
          end
        end else begin
          miss_start = 1'b1;
          vic_d      = vic_sel;
          idx_d      = i_index;
          rtag_d     = i_tag;
          cnt_d      = 4'd0;
          miss_d     = 1'b1;
          state_d    = (valid_q[i_index][vic_sel] && dirty_q[i_index][vic_sel]) ? S_EVICT : S_REFILL;
        end
      end
      S_EVICT: begin
        ev_d      = 1'b1;
        ev_data_d = data_mem[{vic_q, idx_q, cnt_q}];
        ev_addr_d = {tag_mem[vic_q][idx_q], idx_q, cnt_q, 2'b00};
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_REFILL;
      end
      S_REFILL: begin
        if (i_memory_response) begin
          mem_we    = 1'b1;
          mem_waddr = {vic_q, idx_q, cnt_q};
          mem_wdat  = i_memory_line;
          line_d    = i_memory_line;
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            fill_done = 1'b1;
            miss_d    = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      vic_q     <= 2'd0;
      idx_q     <= 8'd0;
      rtag_q    <= 18'd0;
      data_q    <= 32'd0;
      line_q    <= 32'd0;
      ev_data_q <= 32'd0;
      ev_addr_q <= 32'd0;
      miss_q    <= 1'b0;
      ev_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vic_q     <= vic_d;
      idx_q     <= idx_d;
      rtag_q    <= rtag_d;
      data_q    <= data_d;
      line_q    <= line_d;
      ev_data_q <= ev_data_d;
      ev_addr_q <= ev_addr_d;
      miss_q    <= miss_d;
      ev_q      <= ev_d;
    end
  end

  // The victim is invalidated at miss time so an aborted refill never leaves a live line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 256; s++) begin
        valid_q[s] <= 4'd0;
        dirty_q[s] <= 4'd0;
        for (int w = 0; w < 4; w++) age_q[s][w] <= 2'(w);
      end
    end else begin
      if (lru_upd) begin
        for (int w = 0; w < 4; w++) begin
          if (2'(w) == hit_way)
            age_q[i_index][w] <= 2'd0;
          else if (age_q[i_index][w] < age_q[i_index][hit_way])
            age_q[i_index][w] <= age_q[i_index][w] + 2'd1;
        end
      end
      if (st_wr) dirty_q[i_index][hit_way] <= 1'b1;
      if (miss_start) begin
        valid_q[i_index][vic_sel] <= 1'b0;
        dirty_q[i_index][vic_sel] <= 1'b0;
      end
      if (fill_done) valid_q[idx_q][vic_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) tag_mem[vic_q][idx_q] <= rtag_q;
    if (mem_we) data_mem[mem_waddr] <= mem_wdat;
  end

  assign o_data       = data_q;
  assign line_data    = line_q;
  assign cache_miss   = miss_q;
  assign o_evict_data = ev_data_q;
  assign o_evict_addr = ev_addr_q;
  assign o_evict      = ev_q;

endmodule

// File: tb/tb_sa_cache_4way.sv
// Self-checking bench for sa_cache_4way: table of accesses with hand-computed results,
// scoreboard queues for load data and write-back beats, plus a mid-refill reset sequence.
module tb_sa_cache_4way;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] i_tag;
  logic [7:0]  i_index;
  logic [5:0]  i_offset;
  logic [31:0] dataW;
  logic        memRW;
  logic [31:0] i_memory_line;
  logic        i_memory_response;
  logic [31:0] o_data, line_data, o_evict_data, o_evict_addr;
  logic        cache_miss, o_evict;

  sa_cache_4way dut (
    .clk(clk), .rst(rst), .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
    .dataW(dataW), .memRW(memRW), .i_memory_line(i_memory_line),
    .i_memory_response(i_memory_response), .o_data(o_data), .line_data(line_data),
    .cache_miss(cache_miss), .o_evict_data(o_evict_data), .o_evict_addr(o_evict_addr),
    .o_evict(o_evict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] tag;
    logic [7:0]  idx;
    logic [5:0]  off;
    logic        rw;
    logic [31:0] wd;
    logic        miss;
    logic        dirty;
    logic [17:0] ev_tag;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] rd_q[$];
  logic [63:0] ev_q[$];
  logic [31:0] shadow [logic [29:0]];
  logic [31:0] last_load;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_rd(input string name, input logic [31:0] act);
    if (rd_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: load result %h with no expectation queued", name, act);
    end else begin
      check(name, act, rd_q.pop_front());
    end
  endtask

  function automatic logic [31:0] fill_val(input logic [17:0] t, input logic [7:0] i, input int k);
    return 32'h100 + 32'(k) + ({14'd0, t} << 12) + ({24'd0, i} << 20);
  endfunction

  function automatic void add(input logic [17:0] t, input logic [7:0] i, input logic [5:0] o,
                              input logic rw, input logic [31:0] wd, input logic m,
                              input logic d, input logic [17:0] et, input logic [31:0] e);
    vec_t v;
    v.tag = t; v.idx = i; v.off = o; v.rw = rw; v.wd = wd;
    v.miss = m; v.dirty = d; v.ev_tag = et; v.exp = e;
    vecs.push_back(v);
  endfunction

  // Write-back monitor: every beat must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (rst && o_evict) begin
      if (ev_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evict_unexpected: addr %h data %h", o_evict_addr, o_evict_data);
      end else begin
        logic [63:0] e;
        e = ev_q.pop_front();
        check("evict_addr", o_evict_addr, e[63:32]);
        check("evict_data", o_evict_data, e[31:0]);
      end
    end
  end

  task automatic run_vec(input int n, input vec_t v);
    @(negedge clk);
    i_tag = v.tag; i_index = v.idx; i_offset = v.off; memRW = v.rw; dataW = v.wd;
    i_memory_response = 1'b0;
    if (!v.rw) rd_q.push_back(v.exp);
    @(posedge clk); #1;
    check($sformatf("v%0d_miss", n), {31'd0, cache_miss}, {31'd0, v.miss});
    if (v.miss) begin
      check($sformatf("v%0d_evict_registered", n), {31'd0, o_evict}, 32'd0);
      if (v.dirty) begin
        for (int k = 0; k < 16; k++)
          ev_q.push_back({v.ev_tag, v.idx, 4'(k), 2'b00, shadow[{v.ev_tag, v.idx, 4'(k)}]});
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          i_memory_response = 1'b1;
          i_memory_line = 32'hBADB_AD00;
          @(posedge clk); #1;
          check($sformatf("v%0d_evict_beat%0d", n, k), {31'd0, o_evict}, 32'd1);
        end
      end
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (k == 5) begin
          i_memory_response = 1'b0;
          i_memory_line = 32'hBAD0_0005;
          @(negedge clk);
        end
        i_memory_response = 1'b1;
        i_memory_line = fill_val(v.tag, v.idx, k);
        @(posedge clk); #1;
        if (k == 0) check($sformatf("v%0d_evict_done", n), {31'd0, o_evict}, 32'd0);
        if (k == 8) check($sformatf("v%0d_miss_held", n), {31'd0, cache_miss}, 32'd1);
        if (k == 15) begin
          check($sformatf("v%0d_miss_clear", n), {31'd0, cache_miss}, 32'd0);
          check($sformatf("v%0d_line_data", n), line_data, fill_val(v.tag, v.idx, 15));
        end
      end
      for (int k = 0; k < 16; k++) shadow[{v.tag, v.idx, 4'(k)}] = fill_val(v.tag, v.idx, k);
      @(negedge clk);
      i_memory_response = 1'b0;
      @(posedge clk); #1;
      check($sformatf("v%0d_replay_nomiss", n), {31'd0, cache_miss}, 32'd0);
    end
    if (v.rw) begin
      check($sformatf("v%0d_store_keeps_odata", n), o_data, last_load);
      shadow[{v.tag, v.idx, v.off[5:2]}] = v.wd;
    end else begin
      pop_rd($sformatf("v%0d_load_data", n), o_data);
      last_load = v.exp;
    end
  endtask

  localparam int RST_AT = 26;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // tag, idx, off, rw, wdata, miss, dirty, victim tag, expected load data
    add(18'd0, 8'd0, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0000_0100);
    add(18'd0, 8'd0, 6'h04, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_0101);
    add(18'd0, 8'd0, 6'h08, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_0102);
    add(18'd0, 8'd0, 6'h0C, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_0103);
    add(18'd0, 8'd0, 6'h10, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_0104);
    add(18'd0, 8'd0, 6'h08, 1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 18'd0, 32'h0);
    add(18'd0, 8'd0, 6'h08, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'hDEAD_BEEF);
    add(18'd1, 8'd0, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0000_1100);
    add(18'd2, 8'd0, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0000_2100);
    add(18'd3, 8'd0, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0000_3100);
    add(18'd4, 8'd0, 6'h00, 1'b0, 32'h0,         1'b1, 1'b1, 18'd0, 32'h0000_4100);
    add(18'd1, 8'd0, 6'h04, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_1101);
    add(18'd2, 8'd0, 6'h04, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_2101);
    add(18'd3, 8'd0, 6'h04, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_3101);
    add(18'd4, 8'd0, 6'h04, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_4101);
    add(18'd5, 8'd0, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0000_5100);
    add(18'd2, 8'd0, 6'h3C, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_210F);
    add(18'd4, 8'd0, 6'h08, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_4102);
    add(18'd1, 8'd0, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0000_1100);
    add(18'd3, 8'd0, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0000_3100);
    add(18'd0, 8'd5, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0050_0100);
    add(18'd6, 8'd5, 6'h14, 1'b1, 32'hCAFEF00D,  1'b1, 1'b0, 18'd0, 32'h0);
    add(18'd6, 8'd5, 6'h14, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'hCAFE_F00D);
    add(18'd4, 8'd0, 6'h0C, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0000_4103);
    add(18'd0, 8'd5, 6'h3C, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0050_010F);
    add(18'd6, 8'd5, 6'h00, 1'b0, 32'h0,         1'b0, 1'b0, 18'd0, 32'h0050_6100);
    add(18'd7, 8'd9, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0090_7100);
    add(18'd4, 8'd0, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0, 18'd0, 32'h0000_4100);

    rst = 1'b0;
    i_tag = '0; i_index = '0; i_offset = '0; dataW = '0; memRW = 1'b0;
    i_memory_line = '0; i_memory_response = 1'b0;
    last_load = 32'd0;
    #12;
    check("rst_o_data", o_data, 32'd0);
    check("rst_line_data", line_data, 32'd0);
    check("rst_cache_miss", {31'd0, cache_miss}, 32'd0);
    check("rst_o_evict", {31'd0, o_evict}, 32'd0);
    check("rst_evict_addr", o_evict_addr, 32'd0);
    check("rst_evict_data", o_evict_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < RST_AT; n++) run_vec(n, vecs[n]);

    // Reset lands while refill word 7 is being presented: the line must not survive.
    @(negedge clk);
    i_tag = 18'd7; i_index = 8'd9; i_offset = 6'h00; memRW = 1'b0;
    @(posedge clk); #1;
    check("abort_miss", {31'd0, cache_miss}, 32'd1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      i_memory_response = 1'b1;
      i_memory_line = fill_val(18'd7, 8'd9, k);
      @(posedge clk);
    end
    @(negedge clk);
    i_memory_line = fill_val(18'd7, 8'd9, 7);
    #2 rst = 1'b0;
    #1;
    check("abort_o_data", o_data, 32'd0);
    check("abort_line_data", line_data, 32'd0);
    check("abort_cache_miss", {31'd0, cache_miss}, 32'd0);
    check("abort_o_evict", {31'd0, o_evict}, 32'd0);
    check("abort_evict_addr", o_evict_addr, 32'd0);
    check("abort_evict_data", o_evict_data, 32'd0);
    @(negedge clk);
    i_memory_response = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_load = 32'd0;

    for (int n = RST_AT; n < vecs.size(); n++) run_vec(n, vecs[n]);

    repeat (3) @(posedge clk);
    #1;
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("evict_queue_drained", 32'(ev_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
